max2831_spi_arbiter: RTL and testbench

MAX2831_SPI_ARBITER -- requirements
Module: max2831_spi_arbiter

---
 rtl/max2831_pkg.sv | 37 +++
 rtl/max2831_spi_shift.sv | 68 ++++++
 rtl/max2831_spi_arbiter.sv | 124 ++++++++++++
 tb/tb_max2831_spi_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/max2831_pkg.sv
// Shared types and sizes for the MAX2831 SPI arbiter and its serializer.
// Holds the arbitration state encoding and the round-robin pick helper.
// No logic of its own; imported by every file in this block.
package max2831_pkg;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 14;
    localparam int WORD_W = DATA_W + ADDR_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CS_HOLD = 3'd2,
        RELEASE = 3'd3,
        GAP     = 3'd4
    } arb_state_t;

    // Round-robin winner: scan starting one past the previous winner.
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req,
                                           input logic [1:0]      last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = 2'((int'(last) + i) % NREQ);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/max2831_spi_shift.sv
// 18-bit MSB-first serializer for the MAX2831 3-wire bus.
// Latency: loads on start, 2*SCLK_DIV cycles per bit, done pulses one cycle after the last high phase.
// Backpressure: none; start is only issued by the arbiter while idle.
// Ports: clk/resetn; start + word load a frame; spi_sclk/spi_din drive the bus; done marks frame end.
module max2831_spi_shift
    import max2831_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [WORD_W-1:0] word,
    output logic              spi_sclk,
    output logic              spi_din,
    output logic              done
);

    logic              active;
    logic [WORD_W-1:0] shreg;
    logic [7:0]        half_cnt;
    logic [4:0]        bit_cnt;

    // The bus data bit is the MSB of the shift register, so it only moves
    // on the edge that drops spi_sclk and stays put through the high phase.
    assign spi_din = shreg[WORD_W-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active   <= 1'b0;
            shreg    <= '0;
            half_cnt <= 8'd0;
            bit_cnt  <= 5'd0;
            spi_sclk <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                active   <= 1'b1;
                shreg    <= word;
                spi_sclk <= 1'b0;
                half_cnt <= 8'd0;
                bit_cnt  <= 5'd0;
            end else if (active) begin
                if (half_cnt == 8'(SCLK_DIV - 1)) begin
                    half_cnt <= 8'd0;
                    if (!spi_sclk) begin
                        spi_sclk <= 1'b1;
                    end else begin
                        spi_sclk <= 1'b0;
                        if (bit_cnt == 5'(WORD_W - 1)) begin
                            active  <= 1'b0;
                            done    <= 1'b1;
                            bit_cnt <= 5'd0;
                            shreg   <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            shreg   <= {shreg[WORD_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    half_cnt <= half_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/max2831_spi_arbiter.sv
// Round-robin arbiter granting three requesters one MAX2831 register write at a time.
// Latency: grant and spi_csn low on the edge after req; spi_csn low 4*SCLK_DIV*... = 2+36*SCLK_DIV+SCLK_DIV cycles.
// Backpressure: max2831_ready low while busy; grant held until the winner drops req.
// Ports: clk/resetn; req/req_addr/req_data per requester; grant one-hot; max2831_ready; spi_csn/spi_sclk/spi_din bus.
module max2831_spi_arbiter
    import max2831_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          grant,
    output logic                     max2831_ready,
    output logic                     spi_csn,
    output logic                     spi_sclk,
    output logic                     spi_din
);

    arb_state_t        state;
    logic [1:0]        cur;
    logic [1:0]        last_winner;
    logic [1:0]        win;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] cand;
    logic              start;
    logic              done;
    logic              req_dropped;
    logic [8:0]        cnt;

    always_comb win = rr_pick(req, last_winner);

    always_comb begin
        cand = {req_data[DATA_W-1:0], req_addr[ADDR_W-1:0]};
        case (win)
            2'd1:    cand = {req_data[2*DATA_W-1:DATA_W], req_addr[2*ADDR_W-1:ADDR_W]};
            2'd2:    cand = {req_data[3*DATA_W-1:2*DATA_W], req_addr[3*ADDR_W-1:2*ADDR_W]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            grant         <= '0;
            max2831_ready <= 1'b1;
            spi_csn       <= 1'b1;
            cur           <= 2'd0;
            last_winner   <= 2'd2;
            word          <= '0;
            start         <= 1'b0;
            req_dropped   <= 1'b0;
            cnt           <= 9'd0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        cur           <= win;
                        word          <= cand;
                        grant         <= 3'b001 << win;
                        max2831_ready <= 1'b0;
                        spi_csn       <= 1'b0;
                        start         <= 1'b1;
                        req_dropped   <= 1'b0;
                        state         <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Remember an early withdrawal so RELEASE needs no
                    // further handshake even if req is raised again later.
                    if (!req[cur]) req_dropped <= 1'b1;
                    if (done) begin
                        cnt   <= 9'd0;
                        state <= CS_HOLD;
                    end
                end
                CS_HOLD: begin
                    if (!req[cur]) req_dropped <= 1'b1;
                    if (cnt == 9'(SCLK_DIV - 1)) begin
                        cnt     <= 9'd0;
                        spi_csn <= 1'b1;
                        state   <= RELEASE;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                RELEASE: begin
                    if (req_dropped || !req[cur]) begin
                        grant       <= '0;
                        last_winner <= cur;
                        cnt         <= 9'd0;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    if (cnt == 9'(2 * SCLK_DIV - 1)) begin
                        cnt           <= 9'd0;
                        max2831_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    max2831_spi_shift #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shift (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .word     (word),
        .spi_sclk (spi_sclk),
        .spi_din  (spi_din),
        .done     (done)
    );

endmodule

// File: tb/tb_max2831_spi_arbiter.sv
// Directed bench for max2831_spi_arbiter with SCLK_DIV=2.
// Drives on negedge, samples on negedge; a monitor captures each SPI frame.
// Expected words, lengths and grant orders are hand-computed constants.
module tb_max2831_spi_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  req;
    logic [11:0] req_addr;
    logic [41:0] req_data;
    logic [2:0]  grant;
    logic        max2831_ready;
    logic        spi_csn;
    logic        spi_sclk;
    logic        spi_din;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame monitor state
    logic [17:0] cap_word    = '0;
    int          cap_cnt     = 0;
    int          csn_low_cnt = 0;
    int          din_err     = 0;
    int          twohot_err  = 0;
    logic        prev_csn    = 1'b1;
    logic        prev_sclk   = 1'b0;
    logic        prev_din    = 1'b0;

    always #5 clk = ~clk;

    max2831_spi_arbiter #(.SCLK_DIV(2)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req           (req),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .grant         (grant),
        .max2831_ready (max2831_ready),
        .spi_csn       (spi_csn),
        .spi_sclk      (spi_sclk),
        .spi_din       (spi_din)
    );

    always @(negedge clk) begin
        if (prev_csn && !spi_csn) begin
            cap_word    = '0;
            cap_cnt     = 0;
            csn_low_cnt = 0;
        end
        if (!spi_csn) csn_low_cnt++;
        if (!spi_csn && spi_sclk && !prev_sclk) begin
            cap_word = {cap_word[16:0], spi_din};
            cap_cnt++;
        end
        if (spi_sclk && prev_sclk && (spi_din !== prev_din)) din_err++;
        if ($countones(grant) > 1) twohot_err++;
        prev_csn  = spi_csn;
        prev_sclk = spi_sclk;
        prev_din  = spi_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req    = 3'b000;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int t;
        int t_csn;
        int t_g0;
        int ok_cnt;
        logic [2:0] glog [4];

        resetn   = 1'b0;
        req      = 3'b000;
        req_addr = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_grant", {29'd0, grant}, 32'd0);
        check("rst_ready", {31'd0, max2831_ready}, 32'd1);
        check("rst_csn",   {31'd0, spi_csn}, 32'd1);
        check("rst_sclk",  {31'd0, spi_sclk}, 32'd0);
        check("rst_din",   {31'd0, spi_din}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Single transfer, AFC drops req on its first granted cycle,
        // and the source data changes mid-shift.
        req_addr[3:0]  = 4'h5;
        req_data[13:0] = 14'h1A2B;
        req            = 3'b001;
        @(negedge clk);
        check("s1_grant", {29'd0, grant}, 32'b001);
        check("s1_ready", {31'd0, max2831_ready}, 32'd0);
        check("s1_csn",   {31'd0, spi_csn}, 32'd0);
        req[0] = 1'b0;
        repeat (6) @(negedge clk);
        req_data[13:0] = 14'h3FFF;
        req_addr[3:0]  = 4'hA;
        t = 0; t_csn = -1; t_g0 = -1;
        while (!max2831_ready && t < 300) begin
            @(negedge clk);
            t++;
            if (spi_csn && t_csn < 0) t_csn = t;
            if (grant == 3'b000 && t_g0 < 0) t_g0 = t;
        end
        check("s1_timeout", {31'd0, (t < 300)}, 32'd1);
        check("s1_word",    {14'd0, cap_word}, {14'd0, 14'h1A2B, 4'h5});
        check("s1_bits",    cap_cnt, 32'd18);
        check("s1_csn_len", csn_low_cnt, 32'd76);
        check("s1_release", t_g0 - t_csn, 32'd1);
        check("s1_gap",     t - t_g0, 32'd4);
        check("s1_din_stable", din_err, 32'd0);
        repeat (10) @(negedge clk);
        check("s1_no_retx_grant", {29'd0, grant}, 32'd0);
        check("s1_no_retx_csn",   {31'd0, spi_csn}, 32'd1);

        // Held request: grant stays until req[1] falls.
        req_addr[7:4]   = 4'h3;
        req_data[27:14] = 14'h2C4D;
        req             = 3'b010;
        @(negedge clk);
        check("s2_grant", {29'd0, grant}, 32'b010);
        t = 0;
        while (!spi_csn && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("s2_timeout", {31'd0, (t < 300)}, 32'd1);
        ok_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (grant == 3'b010 && !max2831_ready) ok_cnt++;
        end
        check("s2_held", ok_cnt, 32'd10);
        req[1] = 1'b0;
        @(negedge clk);
        check("s2_grant_clr", {29'd0, grant}, 32'd0);
        check("s2_gap_ready", {31'd0, max2831_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("s2_gap_end_m1", {31'd0, max2831_ready}, 32'd0);
        @(negedge clk);
        check("s2_gap_end", {31'd0, max2831_ready}, 32'd1);
        check("s2_word", {14'd0, cap_word}, {14'd0, 14'h2C4D, 4'h3});

        // All three requesting: round-robin order from reset.
        do_reset();
        req_addr = {4'hC, 4'hB, 4'hA};
        req_data = {14'h0111, 14'h0222, 14'h0333};
        req      = 3'b111;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (grant == 3'b000 && t < 300) begin
                @(negedge clk);
                t++;
            end
            glog[k] = grant;
            req     = req & ~grant;
            t = 0;
            while (!max2831_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            check("s3_timeout", {31'd0, (t < 300)}, 32'd1);
            req = 3'b111;
        end
        req = 3'b000;
        check("s3_g0", {29'd0, glog[0]}, 32'b001);
        check("s3_g1", {29'd0, glog[1]}, 32'b010);
        check("s3_g2", {29'd0, glog[2]}, 32'b100);
        check("s3_g3", {29'd0, glog[3]}, 32'b001);
        check("s3_onehot", twohot_err, 32'd0);

        // Reset mid-transfer, then a clean frame from requester 2.
        do_reset();
        req_data[13:0] = 14'h0555;
        req            = 3'b001;
        @(negedge clk);
        t = 0;
        while (cap_cnt != 7 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("s4_reach_bit7", {31'd0, (t < 300)}, 32'd1);
        resetn = 1'b0;
        req    = 3'b000;
        #1;
        check("s4_abort_csn",   {31'd0, spi_csn}, 32'd1);
        check("s4_abort_grant", {29'd0, grant}, 32'd0);
        check("s4_abort_ready", {31'd0, max2831_ready}, 32'd1);
        check("s4_abort_sclk",  {31'd0, spi_sclk}, 32'd0);
        @(negedge clk);
        resetn          = 1'b1;
        req_addr[11:8]  = 4'hC;
        req_data[41:28] = 14'h1234;
        req             = 3'b100;
        @(negedge clk);
        check("s4_grant", {29'd0, grant}, 32'b100);
        req = 3'b000;
        t = 0;
        while (!max2831_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("s4_timeout", {31'd0, (t < 300)}, 32'd1);
        check("s4_bits",    cap_cnt, 32'd18);
        check("s4_word",    {14'd0, cap_word}, {14'd0, 14'h1234, 4'hC});
        check("s4_csn_len", csn_low_cnt, 32'd76);
        check("s4_din_stable", din_err, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
